// File: rtl/pulse_stretch_fsm.sv
// -----------------------------------------------------------------------------
// pulse_stretch_fsm
//   Turns single-cycle event ticks into a clean level. Each accepted tick gives
//   a high pulse of HIGH_CYC cycles. That pulse is followed by a low gap of at
//   least GAP_CYC cycles. A tick that arrives during the gap is remembered and
//   fires as soon as the gap ends. Ticks that cannot be honoured are counted in
//   a saturating drop counter.
//
// Ports
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous, active-low reset
//   tick      in   event strobe; each high cycle counts as one tick
//   clr_drop  in   synchronous clear of drop_cnt
//   level     out  stretched pulse (registered, high only in HIGH)
//   busy      out  high whenever the FSM is not idle (registered)
//   pending   out  a tick was captured during GAP and waits to fire
//   drop_cnt  out  saturating count of discarded ticks
// -----------------------------------------------------------------------------
module pulse_stretch_fsm #(
    parameter int unsigned HIGH_CYC  = 4,  // >= 1
    parameter int unsigned GAP_CYC   = 2,  // >= 0
    parameter int unsigned RETRIGGER = 0,  // nonzero: tick in HIGH reloads count
    parameter int unsigned CNT_W     = 8,  // holds max(HIGH_CYC, GAP_CYC) - 1
    parameter int unsigned DROP_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              clr_drop,
    output logic              level,
    output logic              busy,
    output logic              pending,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_GAP  = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                level_q, busy_q;
    logic                drop_ev;

    // Next-state and counter logic.
    // NOTE: every signal gets a default at the top of the block so that no path
    // leaves it unassigned; otherwise synthesis infers latches.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        drop_ev   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pending_d = 1'b0;
                if (tick) begin
                    state_d = ST_HIGH;
                    cnt_d   = HIGH_LOAD;
                end
            end

            ST_HIGH: begin
                if (tick && (RETRIGGER != 0)) begin
                    // The reload takes priority over leaving HIGH on the last cycle.
                    cnt_d = HIGH_LOAD;
                end else begin
                    if (tick) drop_ev = 1'b1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (GAP_CYC == 0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end
            end

            ST_GAP: begin
                // One tick can be held during the gap. Any further tick is dropped.
                if (tick) begin
                    if (pending_q) drop_ev   = 1'b1;
                    else           pending_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (pending_q || tick) begin
                    state_d   = ST_HIGH;
                    cnt_d     = HIGH_LOAD;
                    pending_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                // Recover from an illegal encoding.
                state_d   = ST_IDLE;
                cnt_d     = '0;
                pending_d = 1'b0;
            end
        endcase
    end

    // Drop counter. A clear and a drop in the same cycle give a result of 1.
    always_comb begin
        drop_d = drop_q;
        if (clr_drop) begin
            drop_d = drop_ev ? DROP_W'(1) : '0;
        end else if (drop_ev && !(&drop_q)) begin
            drop_d = drop_q + DROP_W'(1);
        end
    end

    // All state and outputs are registered. Outputs are decoded from the next
    // state, so they line up with the state register and do not glitch.
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples its pre-edge value, regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            drop_q    <= '0;
            level_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
            level_q   <= (state_d == ST_HIGH);
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign level    = level_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_pulse_stretch_fsm.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretch_fsm
//   Three instances share one stimulus: the defaults (u_def), RETRIGGER=1
//   (u_rt) and GAP_CYC=0 (u_g0). Each test resets them, drives ticks at fixed
//   cycle numbers and compares the outputs with hand-derived cycle windows.
//   Cycle n is the interval after the n-th rising edge that follows reset
//   release. A tick driven in cycle n is sampled at the edge that opens n+1.
// -----------------------------------------------------------------------------
module tb_pulse_stretch_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       clr_drop;

    logic       lv_def, bz_def, pd_def;
    logic [7:0] dc_def;
    logic       lv_rt, bz_rt, pd_rt;
    logic [7:0] dc_rt;
    logic       lv_g0, bz_g0, pd_g0;
    logic [7:0] dc_g0;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    pulse_stretch_fsm u_def (
        .clk(clk), .reset_n(reset_n), .tick(tick), .clr_drop(clr_drop),
        .level(lv_def), .busy(bz_def), .pending(pd_def), .drop_cnt(dc_def)
    );

    pulse_stretch_fsm #(.RETRIGGER(1)) u_rt (
        .clk(clk), .reset_n(reset_n), .tick(tick), .clr_drop(clr_drop),
        .level(lv_rt), .busy(bz_rt), .pending(pd_rt), .drop_cnt(dc_rt)
    );

    pulse_stretch_fsm #(.GAP_CYC(0)) u_g0 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .clr_drop(clr_drop),
        .level(lv_g0), .busy(bz_g0), .pending(pd_g0), .drop_cnt(dc_g0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0d, want %0d", tag, cyc, obs, exp);
    endtask

    // Advance one cycle. Outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        tick     = 1'b0;
        clr_drop = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_level",   lv_def, 0);
        check("rst_busy",    bz_def, 0);
        check("rst_pending", pd_def, 0);
        check("rst_drop",    dc_def, 0);

        // 1: single tick at c10
        do_reset();
        repeat (22) begin
            tick = (cyc == 10);
            step();
            tick = 1'b0;
            check("t1_level", lv_def, (cyc >= 11 && cyc <= 14));
            check("t1_busy",  bz_def, (cyc >= 11 && cyc <= 16));
        end
        check("t1_drop", dc_def, 0);

        // 2: ticks at c10 and c12
        //    u_def drops the second tick. u_rt reloads and stays high c11..c16.
        do_reset();
        repeat (22) begin
            tick = (cyc == 10 || cyc == 12);
            step();
            tick = 1'b0;
            check("t2_level",    lv_def, (cyc >= 11 && cyc <= 14));
            check("t2_rt_level", lv_rt,  (cyc >= 11 && cyc <= 16));
        end
        check("t2_drop",    dc_def, 1);
        check("t2_rt_drop", dc_rt,  0);

        // 3: RETRIGGER=1 with ticks at c10 and c13 -> high c11..c17, gap c18..c19
        do_reset();
        repeat (24) begin
            tick = (cyc == 10 || cyc == 13);
            step();
            tick = 1'b0;
            check("t3_rt_level", lv_rt, (cyc >= 11 && cyc <= 17));
            check("t3_rt_busy",  bz_rt, (cyc >= 11 && cyc <= 19));
        end

        // 4: ticks at c10, c15 and c16. The c15 tick is held as pending and fires
        //    at c17. The c16 tick arrives while one is already pending and is dropped.
        do_reset();
        repeat (26) begin
            tick = (cyc == 10 || cyc == 15 || cyc == 16);
            step();
            tick = 1'b0;
            check("t4_level",   lv_def, ((cyc >= 11 && cyc <= 14) || (cyc >= 17 && cyc <= 20)));
            check("t4_pending", pd_def, (cyc == 16));
        end
        check("t4_drop", dc_def, 1);

        // 5: asynchronous reset in the middle of a pulse
        do_reset();
        repeat (12) begin
            tick = (cyc == 10);
            step();
            tick = 1'b0;
        end
        check("t5_level_pre", lv_def, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_level_async", lv_def, 0);
        check("t5_busy_async",  bz_def, 0);
        step();
        step();
        reset_n = 1'b1;
        cyc = 0;
        repeat (15) begin
            step();
            check("t5_level_after", lv_def, 0);
        end

        // 6: drop counter saturation, clear-with-drop, plain clear
        do_reset();
        tick = 1'b1;
        repeat (320) step();
        tick = 1'b0;
        check("t6_sat", dc_def, 255);
        repeat (10) step();
        check("t6_sat_hold", dc_def, 255);
        tick = 1'b1;                 // accepted from IDLE
        step();
        clr_drop = 1'b1;             // tick in HIGH is dropped in the same cycle as the clear
        step();
        check("t6_clr_and_drop", dc_def, 1);
        tick = 1'b0;
        step();
        clr_drop = 1'b0;
        check("t6_clr", dc_def, 0);

        // 7: tick on the final HIGH cycle (c14)
        //    GAP_CYC=0: go IDLE and count the drop. RETRIGGER=1: reload wins.
        do_reset();
        repeat (24) begin
            tick = (cyc == 10 || cyc == 14);
            step();
            tick = 1'b0;
            check("t7_g0_level", lv_g0, (cyc >= 11 && cyc <= 14));
            check("t7_g0_busy",  bz_g0, (cyc >= 11 && cyc <= 14));
            check("t7_rt_level", lv_rt, (cyc >= 11 && cyc <= 18));
        end
        check("t7_g0_drop",  dc_g0,  1);
        check("t7_def_drop", dc_def, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
